// File: rtl/npu_pkg.sv
// Shared definitions for the NPU control block: register offsets, identity
// constants, FSM state encoding and interrupt bit positions.
package npu_pkg;
    localparam logic [31:0] REG_CTRL          = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS        = 32'h0000_0004;
    localparam logic [31:0] REG_IRQ_EN        = 32'h0000_0008;
    localparam logic [31:0] REG_IRQ_STAT      = 32'h0000_000C;
    localparam logic [31:0] REG_VERSION       = 32'h0000_0010;
    localparam logic [31:0] REG_CONFIG        = 32'h0000_0014;
    localparam logic [31:0] REG_INSTR_BASE_LO = 32'h0000_0020;
    localparam logic [31:0] REG_INSTR_BASE_HI = 32'h0000_0024;

    localparam logic [31:0] NPU_VERSION = 32'h0001_0000;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_ERR  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction
endpackage

// File: rtl/npu_axil_regs.sv
// AXI4-Lite slave and register file for the NPU control block; exposes the
// enable/start controls and instruction base to the sequencer in npu_top.
module npu_axil_regs
    import npu_pkg::*;
#(
    parameter int PE_ROWS = 16,
    parameter int PE_COLS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [31:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    input  logic [1:0]  fsm_state,
    input  logic        busy,
    input  logic        done,
    input  logic        error,
    input  logic        set_done,
    input  logic        set_err,
    output logic        enable,
    output logic        start,
    output logic [39:0] instr_base,
    output logic        irq
);
    logic        ready_en;
    logic        wr_fire;
    logic        rd_fire;
    logic [3:0]  irq_en;
    logic [1:0]  irq_stat;
    logic [1:0]  irq_set;
    logic [1:0]  irq_clr;
    logic [31:0] base_lo;
    logic [7:0]  base_hi;
    logic [31:0] rd_mux;

    // ready_en keeps every Lite ready low through reset and the cycle it is released in
    assign s_axil_awready = ready_en & ~s_axil_bvalid;
    assign s_axil_wready  = ready_en & ~s_axil_bvalid;
    assign s_axil_arready = ready_en & ~s_axil_rvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;

    assign wr_fire    = s_axil_awvalid & s_axil_wvalid & s_axil_awready;
    assign rd_fire    = s_axil_arvalid & s_axil_arready;
    assign start      = wr_fire && (s_axil_awaddr == REG_CTRL) && s_axil_wstrb[0]
                        && s_axil_wdata[1] && s_axil_wdata[0];
    assign instr_base = {base_hi, base_lo};

    always_comb begin
        irq_set           = '0;
        irq_set[IRQ_DONE] = set_done;
        irq_set[IRQ_ERR]  = set_err;
        irq_clr           = '0;
        if (wr_fire && (s_axil_awaddr == REG_IRQ_STAT) && s_axil_wstrb[0])
            irq_clr = s_axil_wdata[1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (s_axil_araddr)
            REG_CTRL:          rd_mux = {31'd0, enable};
            REG_STATUS:        rd_mux = {26'd0, fsm_state, 1'b0, error, busy, done};
            REG_IRQ_EN:        rd_mux = {28'd0, irq_en};
            REG_IRQ_STAT:      rd_mux = {30'd0, irq_stat};
            REG_VERSION:       rd_mux = NPU_VERSION;
            REG_CONFIG:        rd_mux = {16'(PE_ROWS), 16'(PE_COLS)};
            REG_INSTR_BASE_LO: rd_mux = base_lo;
            REG_INSTR_BASE_HI: rd_mux = {24'd0, base_hi};
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en      <= 1'b0;
            s_axil_bvalid <= 1'b0;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            enable        <= 1'b0;
            irq_en        <= '0;
            irq_stat      <= '0;
            base_lo       <= '0;
            base_hi       <= '0;
            irq           <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_fire)            s_axil_bvalid <= 1'b1;
            else if (s_axil_bready) s_axil_bvalid <= 1'b0;
            if (rd_fire) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_mux;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
            if (wr_fire) begin
                case (s_axil_awaddr)
                    REG_CTRL:          if (s_axil_wstrb[0]) enable <= s_axil_wdata[0];
                    REG_IRQ_EN:        if (s_axil_wstrb[0]) irq_en <= s_axil_wdata[3:0];
                    REG_INSTR_BASE_LO: base_lo <= merge_bytes(base_lo, s_axil_wdata, s_axil_wstrb);
                    REG_INSTR_BASE_HI: if (s_axil_wstrb[0]) base_hi <= s_axil_wdata[7:0];
                    default: ;
                endcase
            end
            // A hardware event beats a simultaneous write-1-to-clear
            irq_stat <= irq_set | (irq_stat & ~irq_clr);
            irq      <= |(irq_stat & irq_en[1:0]);
        end
    end
endmodule

// File: rtl/npu_top.sv
// NPU control top: instruction sequencer FSM fetching 128-bit instructions over
// an AXI4 read master, with the register file in npu_axil_regs.
module npu_top
    import npu_pkg::*;
#(
    parameter int PE_ROWS    = 16,
    parameter int PE_COLS    = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    output logic [39:0]  m_axi_awaddr,
    output logic [7:0]   m_axi_awlen,
    output logic [2:0]   m_axi_awsize,
    output logic [1:0]   m_axi_awburst,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [127:0] m_axi_wdata,
    output logic [15:0]  m_axi_wstrb,
    output logic         m_axi_wlast,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [39:0]  m_axi_araddr,
    output logic [7:0]   m_axi_arlen,
    output logic [2:0]   m_axi_arsize,
    output logic [1:0]   m_axi_arburst,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [127:0] m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rlast,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready,
    input  logic [31:0]  s_axil_awaddr,
    input  logic         s_axil_awvalid,
    output logic         s_axil_awready,
    input  logic [31:0]  s_axil_wdata,
    input  logic [3:0]   s_axil_wstrb,
    input  logic         s_axil_wvalid,
    output logic         s_axil_wready,
    output logic [1:0]   s_axil_bresp,
    output logic         s_axil_bvalid,
    input  logic         s_axil_bready,
    input  logic [31:0]  s_axil_araddr,
    input  logic         s_axil_arvalid,
    output logic         s_axil_arready,
    output logic [31:0]  s_axil_rdata,
    output logic [1:0]   s_axil_rresp,
    output logic         s_axil_rvalid,
    input  logic         s_axil_rready,
    output logic         irq
);
    state_t        state;
    logic [39:0]   pc;
    logic [127:0]  instr;
    logic [7:0]    exec_cnt;
    logic          ar_valid;
    logic          r_ready;
    logic          done;
    logic          error;
    logic          bready_r;
    logic          enable;
    logic          start;
    logic [39:0]   instr_base;
    logic          r_beat;
    logic          set_err;
    logic          set_done;
    logic          unused_bits;

    assign m_axi_awaddr  = '0;
    assign m_axi_awlen   = '0;
    assign m_axi_awsize  = '0;
    assign m_axi_awburst = '0;
    assign m_axi_awvalid = 1'b0;
    assign m_axi_wdata   = '0;
    assign m_axi_wstrb   = '0;
    assign m_axi_wlast   = 1'b0;
    assign m_axi_wvalid  = 1'b0;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = pc;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = ar_valid;
    assign m_axi_rready  = r_ready;

    assign r_beat   = (state == ST_FETCH) && r_ready && m_axi_rvalid;
    assign set_err  = r_beat && (m_axi_rresp != 2'b00);
    assign set_done = (state == ST_DONE);

    assign unused_bits = &{1'b0, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
                           m_axi_rlast, instr[126:16], instr[7:0], 32'(DATA_WIDTH)};

    npu_axil_regs #(.PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS)) u_regs (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .fsm_state      (state),
        .busy           (state != ST_IDLE),
        .done           (done),
        .error          (error),
        .set_done       (set_done),
        .set_err        (set_err),
        .enable         (enable),
        .start          (start),
        .instr_base     (instr_base),
        .irq            (irq)
    );

    // Once an AR is on the bus its R beat is always collected, even if enable drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            instr    <= '0;
            exec_cnt <= '0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            bready_r <= 1'b0;
        end else begin
            bready_r <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        pc       <= instr_base;
                        ar_valid <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (ar_valid && m_axi_arready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                    if (r_beat) begin
                        r_ready  <= 1'b0;
                        instr    <= m_axi_rdata;
                        exec_cnt <= m_axi_rdata[15:8];
                        if (m_axi_rresp != 2'b00) begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end else if (!enable) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (exec_cnt == 8'd0) begin
                        if (instr[127]) begin
                            state <= ST_DONE;
                        end else begin
                            pc       <= pc + 40'd16;
                            ar_valid <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end else begin
                        exec_cnt <= exec_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npu_top.sv
// Self-checking bench for npu_top: register table, directed sequencer scenarios
// and randomized programs against a cycle-count reference model.
module tb_npu_top;
    logic         clk = 1'b0;
    logic         rst;
    logic [39:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b0;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic [39:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [127:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [31:0]  s_axil_awaddr = '0;
    logic         s_axil_awvalid = 1'b0;
    logic         s_axil_awready;
    logic [31:0]  s_axil_wdata = '0;
    logic [3:0]   s_axil_wstrb = '0;
    logic         s_axil_wvalid = 1'b0;
    logic         s_axil_wready;
    logic [1:0]   s_axil_bresp;
    logic         s_axil_bvalid;
    logic         s_axil_bready = 1'b1;
    logic [31:0]  s_axil_araddr = '0;
    logic         s_axil_arvalid = 1'b0;
    logic         s_axil_arready;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rvalid;
    logic         s_axil_rready = 1'b1;
    logic         irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [127:0] mem [logic [39:0]];
    logic [1:0]   mem_resp = 2'b00;
    logic [39:0]  ar_q[$];
    int           ar_cyc_q[$];
    int           beat_cyc_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npu_top #(.PE_ROWS(16), .PE_COLS(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .irq(irq)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        while (!(s_axil_awready && s_axil_wready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeoutFail("axil_write");
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeoutFail("axil_read");
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        if (!s_axil_rvalid) timeoutFail("axil_rvalid");
        d = s_axil_rdata;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] got);
        if (v.wr) axil_write(v.addr, v.data, v.strb);
        axil_read(v.addr, got);
    endtask

    task automatic wait_irq(input int bound, output int at_cyc);
        int n = 0;
        at_cyc = -1;
        while (n < bound && at_cyc < 0) begin
            @(negedge clk);
            if (irq === 1'b1) at_cyc = cyc;
            n++;
        end
        if (at_cyc < 0) timeoutFail("irq_wait");
    endtask

    // Memory slave: one outstanding read, AR accepted one cycle after it appears, R one cycle later
    initial begin
        logic [39:0] addr;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && m_axi_arvalid === 1'b1) begin
                addr = m_axi_araddr;
                ar_q.push_back(addr);
                ar_cyc_q.push_back(cyc);
                checkOutput("arlen", 64'(m_axi_arlen), 64'h0);
                checkOutput("arsize", 64'(m_axi_arsize), 64'h4);
                checkOutput("arburst", 64'(m_axi_arburst), 64'h1);
                m_axi_arready = 1'b1;
                @(negedge clk);
                m_axi_arready = 1'b0;
                checkOutput("rready_after_ar", 64'(m_axi_rready), 64'h1);
                m_axi_rdata = mem.exists(addr) ? mem[addr] : {1'b1, 127'd0};
                m_axi_rresp = mem_resp; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
                @(negedge clk);
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                beat_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] model [4];
        logic [31:0] raddr [4];
        logic [31:0] rmask [4];
        logic [31:0] bmask;
        int irq_at;

        vecs[0]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'h0001_0000};
        vecs[1]  = '{1'b0, 32'h014, 32'h0, 4'h0, 32'h0010_0010};
        vecs[2]  = '{1'b0, 32'h004, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 32'h00C, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b1, 32'h000, 32'h1, 4'hF, 32'h1};
        vecs[5]  = '{1'b1, 32'h008, 32'hF, 4'hF, 32'hF};
        vecs[6]  = '{1'b1, 32'h008, 32'hFFFF_FFFF, 4'hF, 32'hF};
        vecs[7]  = '{1'b1, 32'h020, 32'h1122_3344, 4'hF, 32'h1122_3344};
        vecs[8]  = '{1'b1, 32'h020, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD};
        vecs[9]  = '{1'b1, 32'h024, 32'h1FF, 4'hF, 32'hFF};
        vecs[10] = '{1'b1, 32'h010, 32'h0, 4'hF, 32'h0001_0000};
        vecs[11] = '{1'b1, 32'h100, 32'h5, 4'hF, 32'h0};
        vecs[12] = '{1'b1, 32'h000, 32'h0, 4'hE, 32'h1};
        vecs[13] = '{1'b1, 32'h000, 32'h0, 4'h1, 32'h0};
        vecs[14] = '{1'b1, 32'h000, 32'h3, 4'hF, 32'h1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_awready", 64'(s_axil_awready), 64'h0);
        checkOutput("rst_arready", 64'(s_axil_arready), 64'h0);
        checkOutput("rst_bvalid", 64'(s_axil_bvalid), 64'h0);
        checkOutput("rst_rvalid", 64'(s_axil_rvalid), 64'h0);
        checkOutput("rst_rdata", 64'(s_axil_rdata), 64'h0);
        checkOutput("rst_irq", 64'(irq), 64'h0);
        checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'h0);
        checkOutput("rst_m_rready", 64'(m_axi_rready), 64'h0);
        checkOutput("rst_m_bready", 64'(m_axi_bready), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_awready", 64'(s_axil_awready), 64'h1);
        checkOutput("post_rst_arready", 64'(s_axil_arready), 64'h1);
        checkOutput("post_rst_m_bready", 64'(m_axi_bready), 64'h1);
        checkOutput("awvalid_idle", 64'({m_axi_awvalid, m_axi_wvalid}), 64'h0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], got);
            checkOutput($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].exp));
        end

        // Long single instruction: EXEC length 0xDE+1 cycles, then DONE
        repeat (10) @(negedge clk);
        axil_write(32'h00C, 32'h3, 4'hF);
        axil_write(32'h020, 32'h0, 4'hF);
        axil_write(32'h024, 32'h0, 4'hF);
        axil_write(32'h008, 32'hF, 4'hF);
        mem.delete();
        mem[40'h0] = 128'hDEADBEEF_00000000_12345678_9ABCDEF0;
        ar_q.delete(); ar_cyc_q.delete(); beat_cyc_q.delete();
        axil_write(32'h000, 32'h3, 4'hF);
        repeat (10) @(negedge clk);
        axil_read(32'h004, got);
        checkOutput("status_exec", 64'(got), 64'h22);
        wait_irq(600, irq_at);
        if (beat_cyc_q.size() == 1)
            checkOutput("long_exec_latency", 64'(irq_at - beat_cyc_q[0]), 64'd225);
        else
            checkOutput("long_fetch_count", 64'(beat_cyc_q.size()), 64'd1);
        axil_read(32'h004, got);
        checkOutput("status_done", 64'(got), 64'h01);
        axil_read(32'h00C, got);
        checkOutput("irq_stat_done", 64'(got), 64'h1);

        // Fetch error
        axil_write(32'h00C, 32'h1, 4'hF);
        mem_resp = 2'b10;
        axil_write(32'h000, 32'h3, 4'hF);
        wait_irq(100, irq_at);
        mem_resp = 2'b00;
        axil_read(32'h004, got);
        checkOutput("status_error", 64'(got), 64'h04);
        axil_read(32'h00C, got);
        checkOutput("irq_stat_error", 64'(got), 64'h2);
        axil_write(32'h00C, 32'h2, 4'hF);
        repeat (2) @(negedge clk);
        checkOutput("irq_cleared", 64'(irq), 64'h0);

        // Disable during EXEC
        ar_q.delete(); ar_cyc_q.delete(); beat_cyc_q.delete();
        axil_write(32'h000, 32'h3, 4'hF);
        repeat (10) @(negedge clk);
        axil_write(32'h000, 32'h0, 4'h1);
        axil_read(32'h004, got);
        checkOutput("status_disabled", 64'(got), 64'h00);
        repeat (20) @(negedge clk);
        checkOutput("disabled_fetches", 64'(ar_q.size()), 64'd1);

        // Random register traffic against a byte-lane model
        raddr = '{32'h000, 32'h008, 32'h020, 32'h024};
        rmask = '{32'h1, 32'hF, 32'hFFFF_FFFF, 32'hFF};
        for (int r = 0; r < 4; r++) begin
            model[r] = 32'h0;
            axil_write(raddr[r], 32'h0, 4'hF);
        end
        for (int i = 0; i < 24; i++) begin
            int r;
            logic [31:0] d;
            logic [3:0] s;
            r = $urandom_range(0, 3);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (r == 0) d[1] = 1'b0;
            bmask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            model[r] = ((model[r] & ~bmask) | (d & bmask)) & rmask[r];
            axil_write(raddr[r], d, s);
            axil_read(raddr[r], got);
            checkOutput($sformatf("rand_reg%0d", i), 64'(got), 64'(model[r]));
        end

        // Random programs: address sequence and per-instruction timing
        for (int p = 0; p < 4; p++) begin
            int n;
            int ks[$];
            logic [39:0] base;
            logic [127:0] ins;
            n = $urandom_range(1, 3);
            base = {8'($urandom), 28'($urandom), 4'h0};
            mem.delete();
            ks.delete();
            for (int i = 0; i < n; i++) begin
                ins = {$urandom, $urandom, $urandom, $urandom};
                ins[127] = (i == n - 1);
                ins[15:8] = 8'($urandom_range(0, 7));
                ks.push_back(int'(ins[15:8]));
                mem[base + 40'(16 * i)] = ins;
            end
            axil_write(32'h00C, 32'h3, 4'hF);
            axil_write(32'h020, base[31:0], 4'hF);
            axil_write(32'h024, {24'd0, base[39:32]}, 4'hF);
            axil_write(32'h008, 32'h1, 4'hF);
            ar_q.delete(); ar_cyc_q.delete(); beat_cyc_q.delete();
            axil_write(32'h000, 32'h3, 4'hF);
            wait_irq(500, irq_at);
            checkOutput($sformatf("prog%0d_fetches", p), 64'(ar_q.size()), 64'(n));
            for (int i = 0; i < n && i < ar_q.size(); i++)
                checkOutput($sformatf("prog%0d_araddr%0d", p, i), 64'(ar_q[i]), 64'(base + 40'(16 * i)));
            for (int i = 0; i + 1 < n && i + 1 < ar_cyc_q.size() && i < beat_cyc_q.size(); i++)
                checkOutput($sformatf("prog%0d_exec%0d", p, i), 64'(ar_cyc_q[i + 1] - beat_cyc_q[i]), 64'(ks[i] + 1));
            if (beat_cyc_q.size() == n)
                checkOutput($sformatf("prog%0d_done_lat", p), 64'(irq_at - beat_cyc_q[n - 1]), 64'(ks[n - 1] + 3));
            axil_read(32'h004, got);
            checkOutput($sformatf("prog%0d_status", p), 64'(got), 64'h01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
